// File: rtl/traffic_pkg.sv
// Shared types, default timing and request decode for the three-road
// junction lamp sequencer.
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN   = 2'd0,
    YELLOW  = 2'd1,
    ALL_RED = 2'd2,
    FLASH   = 2'd3
  } tls_state_t;

  typedef enum logic [1:0] {
    ROAD_A = 2'd0,
    ROAD_B = 2'd1,
    ROAD_C = 2'd2
  } road_t;

  localparam int GREEN_MIN_DEFAULT = 8;
  localparam int YELLOW_T_DEFAULT  = 3;
  localparam int ALLRED_T_DEFAULT  = 2;
  localparam int CW_DEFAULT        = 8;

  // A request counts only when exactly one road bit is set.
  function automatic logic req_valid(input logic [2:0] req);
    return (req == 3'b100) || (req == 3'b010) || (req == 3'b001);
  endfunction

  // bit2 = A, bit1 = B, bit0 = C; only meaningful when req_valid() holds.
  function automatic road_t onehot_to_road(input logic [2:0] req);
    road_t road;
    case (req)
      3'b100:  road = ROAD_A;
      3'b010:  road = ROAD_B;
      default: road = ROAD_C;
    endcase
    return road;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: counts up from zero and holds at the limit; done flags
// that the limit has been reached. Synchronous clear wins over counting.
module phase_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic          done
);

  logic [CW-1:0] count;

  // Saturating up-counter with synchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != limit)) begin
      count <= count + CW'(1);
    end
  end

  assign done = (count == limit);

endmodule

// File: rtl/traffic_light_sequencer.sv
// Three-road junction lamp sequencer: green -> yellow -> all-red -> green
// with minimum phase durations. All lamps and busy come from registers.
// Optional maintenance flashing (yellows blink, everything else dark) is
// built when the macro TLS_FLASH_EN is defined; it adds the flash input.
//
// state   | meaning
// GREEN   | active road green, others red; waits for a new valid request
// YELLOW  | active road yellow, others red
// ALL_RED | clearance, every road red; hands right of way to next_road
// FLASH   | maintenance blink of all yellows (TLS_FLASH_EN only)
module traffic_light_sequencer
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN = GREEN_MIN_DEFAULT,
  parameter int YELLOW_T  = YELLOW_T_DEFAULT,
  parameter int ALLRED_T  = ALLRED_T_DEFAULT,
  parameter int CW        = CW_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
`ifdef TLS_FLASH_EN
  input  logic       flash,
`endif
  output logic       VMA,
  output logic       VAA,
  output logic       VDA,
  output logic       VMB,
  output logic       VAB,
  output logic       VDB,
  output logic       VMC,
  output logic       VAC,
  output logic       VDC,
  output logic       busy
);

  localparam logic [CW-1:0] GREEN_LIM  = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] YELLOW_LIM = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] ALLRED_LIM = CW'(ALLRED_T - 1);

  tls_state_t    state, state_d;
  road_t         active, active_d;
  road_t         next_road, next_d;
  logic          flash_on, flash_on_d;
  logic          t_clr, t_done;
  logic [CW-1:0] t_lim;
  logic [2:0]    red_q, yel_q, grn_q;
  logic [2:0]    red_d, yel_d, grn_d, mask_d;
  logic          busy_q, busy_d;

  phase_timer #(.CW(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (t_clr),
    .en    (1'b1),
    .limit (t_lim),
    .done  (t_done)
  );

  // Next-state, timer control and lamp decode of the upcoming state.
  always_comb begin
    state_d    = state;
    active_d   = active;
    next_d     = next_road;
    flash_on_d = flash_on;
    t_clr      = 1'b0;
    t_lim      = GREEN_LIM;
    case (state)
      GREEN: begin
        t_lim = GREEN_LIM;
        if (t_done && req_valid(req) && (onehot_to_road(req) != active)) begin
          next_d  = onehot_to_road(req);
          t_clr   = 1'b1;
          state_d = YELLOW;
        end
      end
      YELLOW: begin
        t_lim = YELLOW_LIM;
        if (t_done) begin
          t_clr   = 1'b1;
          state_d = ALL_RED;
        end
      end
      ALL_RED: begin
        t_lim = ALLRED_LIM;
        if (t_done) begin
          t_clr    = 1'b1;
          active_d = next_road;
          state_d  = GREEN;
        end
      end
      FLASH: begin
        t_lim = YELLOW_LIM;
        if (t_done) begin
          t_clr      = 1'b1;
          flash_on_d = ~flash_on;
        end
      end
      default: begin
        state_d = GREEN;
      end
    endcase
`ifdef TLS_FLASH_EN
    // Flash overrides everything; leaving it always clears through all-red to A.
    if (flash && (state != FLASH)) begin
      state_d    = FLASH;
      t_clr      = 1'b1;
      flash_on_d = 1'b1;
    end else if (!flash && (state == FLASH)) begin
      state_d = ALL_RED;
      next_d  = ROAD_A;
      t_clr   = 1'b1;
    end
`endif

    mask_d = 3'b001 << active_d;
    red_d  = 3'b111;
    yel_d  = 3'b000;
    grn_d  = 3'b000;
    busy_d = 1'b0;
    case (state_d)
      GREEN: begin
        red_d = ~mask_d;
        grn_d = mask_d;
      end
      YELLOW: begin
        red_d  = ~mask_d;
        yel_d  = mask_d;
        busy_d = 1'b1;
      end
      ALL_RED: begin
        busy_d = 1'b1;
      end
      FLASH: begin
        red_d = 3'b000;
        yel_d = {3{flash_on_d}};
      end
      default: begin
        red_d = 3'b111;
      end
    endcase
  end

  // Sequencer state and registered lamp outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= GREEN;
      active    <= ROAD_A;
      next_road <= ROAD_A;
      flash_on  <= 1'b0;
      red_q     <= 3'b110;
      yel_q     <= 3'b000;
      grn_q     <= 3'b001;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_d;
      active    <= active_d;
      next_road <= next_d;
      flash_on  <= flash_on_d;
      red_q     <= red_d;
      yel_q     <= yel_d;
      grn_q     <= grn_d;
      busy_q    <= busy_d;
    end
  end

  assign VMA  = red_q[0];
  assign VMB  = red_q[1];
  assign VMC  = red_q[2];
  assign VAA  = yel_q[0];
  assign VAB  = yel_q[1];
  assign VAC  = yel_q[2];
  assign VDA  = grn_q[0];
  assign VDB  = grn_q[1];
  assign VDC  = grn_q[2];
  assign busy = busy_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Self-checking bench for traffic_light_sequencer. The reference model is a
// schedule: a changeover accepted at cycle t shows yellow on [t, t+Y),
// all-red on [t+Y, t+Y+A) and the new green from t+Y+A.
module tb_traffic_light_sequencer;

  localparam int GM = 8;
  localparam int YT = 3;
  localparam int AT = 2;

  // {VMA,VMB,VMC,VAA,VAB,VAC,VDA,VDB,VDC,busy}
  localparam logic [9:0] V_GREEN_A  = 10'b0110001000;
  localparam logic [9:0] V_GREEN_B  = 10'b1010000100;
  localparam logic [9:0] V_GREEN_C  = 10'b1100000010;
  localparam logic [9:0] V_YELLOW_A = 10'b0111000001;
  localparam logic [9:0] V_YELLOW_B = 10'b1010100001;
  localparam logic [9:0] V_ALL_RED  = 10'b1110000001;

  logic       clk;
  logic       reset;
  logic [2:0] req;
  logic       VMA, VAA, VDA, VMB, VAB, VDB, VMC, VAC, VDC, busy;
`ifdef TLS_FLASH_EN
  logic       flash;
`endif
  logic [9:0] dut_vec;
  logic [9:0] exp;

  int checks;
  int failures;

  int m_active, m_target, m_green_since, m_change_at, m_cyc;

  traffic_light_sequencer #(
    .GREEN_MIN (GM),
    .YELLOW_T  (YT),
    .ALLRED_T  (AT),
    .CW        (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
`ifdef TLS_FLASH_EN
    .flash (flash),
`endif
    .VMA   (VMA),
    .VAA   (VAA),
    .VDA   (VDA),
    .VMB   (VMB),
    .VAB   (VAB),
    .VDB   (VDB),
    .VMC   (VMC),
    .VAC   (VAC),
    .VDC   (VDC),
    .busy  (busy)
  );

  assign dut_vec = {VMA, VMB, VMC, VAA, VAB, VAC, VDA, VDB, VDC, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_active      = 0;
    m_target      = 0;
    m_green_since = 0;
    m_change_at   = -1;
    m_cyc         = 0;
  endtask

  // Expected lamps for the current cycle m_cyc.
  task automatic model_eval(output logic [9:0] e);
    logic [2:0] r, y, g;
    logic       b;
    if (m_change_at >= 0 && m_cyc >= m_change_at + YT + AT) begin
      m_active      = m_target;
      m_green_since = m_change_at + YT + AT;
      m_change_at   = -1;
    end
    r = 3'b111;
    y = 3'b000;
    g = 3'b000;
    b = 1'b0;
    if (m_change_at < 0) begin
      r[m_active] = 1'b0;
      g[m_active] = 1'b1;
    end else if (m_cyc < m_change_at + YT) begin
      r[m_active] = 1'b0;
      y[m_active] = 1'b1;
      b = 1'b1;
    end else begin
      b = 1'b1;
    end
    e = {r[0], r[1], r[2], y[0], y[1], y[2], g[0], g[1], g[2], b};
  endtask

  // Request presented during cycle m_cyc, sampled at the edge ending it.
  task automatic model_sample(input logic [2:0] r);
    int idx;
    idx = r[2] ? 0 : (r[1] ? 1 : 2);
    if (m_change_at < 0 && $countones(r) == 1 && idx != m_active &&
        (m_cyc - m_green_since) >= GM - 1) begin
      m_target    = idx;
      m_change_at = m_cyc + 1;
    end
    m_cyc++;
  endtask

  task automatic tick(input logic [2:0] r);
    req = r;
    model_sample(r);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 3'b000;
`ifdef TLS_FLASH_EN
    flash = 1'b0;
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 3'b000;
`ifdef TLS_FLASH_EN
    flash = 1'b0;
`endif
    #2;
    checks++;
    if (dut_vec !== V_GREEN_A) begin
      failures++;
      $display("FAIL reset_async got=%b exp=%b", dut_vec, V_GREEN_A);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== V_GREEN_A) begin
      failures++;
      $display("FAIL reset_held got=%b exp=%b", dut_vec, V_GREEN_A);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 50; i++) begin
      model_eval(exp);
      checks++;
      if (dut_vec !== exp || dut_vec !== V_GREEN_A) begin
        failures++;
        $display("FAIL idle cyc=%0d got=%b exp=%b", i, dut_vec, V_GREEN_A);
      end
      tick(3'b000);
    end
  endtask

  task automatic test_change_b();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      model_eval(exp);
      checks++;
      if (dut_vec !== exp) begin
        failures++;
        $display("FAIL change_b cyc=%0d got=%b exp=%b", i, dut_vec, exp);
      end
      if (i == 7 || i == 8 || i == 11 || i == 13) begin
        checks++;
        if (dut_vec !== (i == 7 ? V_GREEN_A : i == 8 ? V_YELLOW_A :
                         i == 11 ? V_ALL_RED : V_GREEN_B)) begin
          failures++;
          $display("FAIL change_b_timing cyc=%0d got=%b", i, dut_vec);
        end
      end
      tick(3'b010);
    end
  endtask

  task automatic test_invalid();
    logic [2:0] r;
    do_reset();
    for (int i = 0; i < 26; i++) begin
      model_eval(exp);
      checks++;
      if (dut_vec !== exp) begin
        failures++;
        $display("FAIL invalid cyc=%0d got=%b exp=%b", i, dut_vec, exp);
      end
      if (i == 15 || i == 16 || i == 21) begin
        checks++;
        if (dut_vec !== (i == 15 ? V_GREEN_A : i == 16 ? V_YELLOW_A : V_GREEN_C)) begin
          failures++;
          $display("FAIL invalid_timing cyc=%0d got=%b", i, dut_vec);
        end
      end
      r = (i < 12) ? 3'b011 : (i < 15) ? 3'b000 : 3'b001;
      tick(r);
    end
  endtask

  task automatic test_latch();
    logic [2:0] r;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      model_eval(exp);
      checks++;
      if (dut_vec !== exp) begin
        failures++;
        $display("FAIL latch cyc=%0d got=%b exp=%b", i, dut_vec, exp);
      end
      if (i == 13 || i == 20 || i == 21 || i == 26) begin
        checks++;
        if (dut_vec !== (i == 13 ? V_GREEN_B : i == 20 ? V_GREEN_B :
                         i == 21 ? V_YELLOW_B : V_GREEN_C)) begin
          failures++;
          $display("FAIL latch_timing cyc=%0d got=%b", i, dut_vec);
        end
      end
      r = (i < 8) ? 3'b010 : 3'b001;
      tick(r);
    end
  endtask

  task automatic test_reset_midway();
    do_reset();
    for (int i = 0; i < 11; i++) begin
      model_eval(exp);
      checks++;
      if (dut_vec !== exp) begin
        failures++;
        $display("FAIL midway_pre cyc=%0d got=%b exp=%b", i, dut_vec, exp);
      end
      tick(3'b010);
    end
    checks++;
    if (dut_vec !== V_ALL_RED) begin
      failures++;
      $display("FAIL midway_allred got=%b exp=%b", dut_vec, V_ALL_RED);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (dut_vec !== V_GREEN_A) begin
      failures++;
      $display("FAIL midway_async got=%b exp=%b", dut_vec, V_GREEN_A);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      model_eval(exp);
      checks++;
      if (dut_vec !== exp) begin
        failures++;
        $display("FAIL midway_post cyc=%0d got=%b exp=%b", i, dut_vec, exp);
      end
      if (i == 7 || i == 8) begin
        checks++;
        if (dut_vec !== (i == 7 ? V_GREEN_A : V_YELLOW_A)) begin
          failures++;
          $display("FAIL midway_full_green cyc=%0d got=%b", i, dut_vec);
        end
      end
      tick(3'b010);
    end
  endtask

  task automatic test_random();
    logic [2:0] r;
    int         hold;
    logic [2:0] red, nonred;
    hold = 0;
    r    = 3'b000;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      model_eval(exp);
      checks++;
      if (dut_vec !== exp) begin
        failures++;
        $display("FAIL random cyc=%0d req=%b got=%b exp=%b", i, req, dut_vec, exp);
      end
      red    = {VMA, VMB, VMC};
      nonred = ~red;
      checks++;
      if ($countones({VMA, VAA, VDA}) != 1 || $countones({VMB, VAB, VDB}) != 1 ||
          $countones({VMC, VAC, VDC}) != 1 || $countones(nonred) > 1) begin
        failures++;
        $display("FAIL random_invariant cyc=%0d got=%b", i, dut_vec);
      end
      if (hold == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          r = 3'b001 << $urandom_range(0, 2);
        end else begin
          r = 3'($urandom_range(0, 7));
        end
        hold = $urandom_range(1, 12);
      end
      hold--;
      tick(r);
    end
  endtask

`ifdef TLS_FLASH_EN
  task automatic test_flash();
    logic [9:0] fexp;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      model_eval(exp);
      checks++;
      if (dut_vec !== exp) begin
        failures++;
        $display("FAIL flash_pre cyc=%0d got=%b exp=%b", i, dut_vec, exp);
      end
      tick(3'b010);
    end
    req   = 3'b000;
    flash = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      fexp = (((i / YT) % 2) == 0) ? 10'b0001110000 : 10'b0000000000;
      checks++;
      if (dut_vec !== fexp) begin
        failures++;
        $display("FAIL flash_blink idx=%0d got=%b exp=%b", i, dut_vec, fexp);
      end
      @(posedge clk);
      #1;
    end
    flash = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      fexp = (i < AT) ? V_ALL_RED : V_GREEN_A;
      checks++;
      if (dut_vec !== fexp) begin
        failures++;
        $display("FAIL flash_exit idx=%0d got=%b exp=%b", i, dut_vec, fexp);
      end
      @(posedge clk);
      #1;
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    test_reset();
    test_idle();
    test_change_b();
    test_invalid();
    test_latch();
    test_reset_midway();
    test_random();
`ifdef TLS_FLASH_EN
    test_flash();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
